// File: rtl/wash_plant_model.sv
// Plant-side model for the washing machine controller: tank level, soap dispenser,
// wash timer and dry timer, all returned to the controller as registered sensor flags.
module wash_plant_model #(
    parameter int unsigned FILL_CYCLES = 4,
    parameter int unsigned SOAP_CYCLES = 2,
    parameter int unsigned WASH_CYCLES = 8,
    parameter int unsigned DRY_CYCLES  = 6,
    parameter int unsigned CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             door_lock,
    input  logic             motor_on,
    input  logic             fill_valve_on,
    input  logic             drain_valve_on,
    input  logic             soap_wash,
    input  logic             water_wash,
    input  logic             done,
    output logic             filled,
    output logic             soap_added,
    output logic             wash_timeout,
    output logic             drained,
    output logic             drying_timeout,
    output logic [CNT_W-1:0] water_level,
    output logic             fault
);

    localparam logic [CNT_W-1:0] FILL_MAX = CNT_W'(FILL_CYCLES);
    localparam logic [CNT_W-1:0] SOAP_MAX = CNT_W'(SOAP_CYCLES);
    localparam logic [CNT_W-1:0] WASH_MAX = CNT_W'(WASH_CYCLES);
    localparam logic [CNT_W-1:0] DRY_MAX  = CNT_W'(DRY_CYCLES);

    logic [CNT_W-1:0] soap_cnt, wash_cnt, dry_cnt;
    logic [CNT_W-1:0] level_n, soap_n, wash_n, dry_n;
    logic             fault_n, dry_qual, wash_qual;

    always_comb begin
        level_n = water_level;
        fault_n = fault;
        if (drain_valve_on && fill_valve_on) begin
            fault_n = 1'b1;
        end else if (drain_valve_on) begin
            if (water_level != '0) level_n = water_level - 1'b1;
        end else if (fill_valve_on && door_lock) begin
            if (water_level != FILL_MAX) level_n = water_level + 1'b1;
        end

        // Soap is considered washed away once the tank has emptied.
        soap_n = soap_cnt;
        if (done || level_n == '0)
            soap_n = '0;
        else if (soap_wash && motor_on && water_level == FILL_MAX && soap_cnt != SOAP_MAX)
            soap_n = soap_cnt + 1'b1;

        wash_qual = door_lock && (water_level == FILL_MAX) && (soap_wash || water_wash);
        wash_n = wash_cnt;
        if (done || !motor_on)
            wash_n = '0;
        else if (wash_qual && wash_cnt != WASH_MAX)
            wash_n = wash_cnt + 1'b1;

        dry_qual = door_lock && (water_level == '0) &&
                   !(motor_on || fill_valve_on || drain_valve_on || soap_wash || water_wash);
        dry_n = dry_cnt;
        if (done || !dry_qual)
            dry_n = '0;
        else if (dry_cnt != DRY_MAX)
            dry_n = dry_cnt + 1'b1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            water_level    <= '0;
            soap_cnt       <= '0;
            wash_cnt       <= '0;
            dry_cnt        <= '0;
            filled         <= 1'b0;
            soap_added     <= 1'b0;
            wash_timeout   <= 1'b0;
            drained        <= 1'b0;
            drying_timeout <= 1'b0;
            fault          <= 1'b0;
        end else begin
            water_level    <= level_n;
            soap_cnt       <= soap_n;
            wash_cnt       <= wash_n;
            dry_cnt        <= dry_n;
            filled         <= (level_n == FILL_MAX);
            soap_added     <= (soap_n == SOAP_MAX);
            wash_timeout   <= (wash_n == WASH_MAX);
            drained        <= (level_n == '0) && drain_valve_on;
            drying_timeout <= (dry_n == DRY_MAX);
            fault          <= fault_n;
        end
    end

endmodule

// File: tb/tb_wash_plant_model.sv
// Directed self-checking bench for wash_plant_model with hand-computed expectations.
module tb_wash_plant_model;

    logic       clk = 1'b0;
    logic       reset, door_lock, motor_on, fill_valve_on, drain_valve_on;
    logic       soap_wash, water_wash, done;
    logic       filled, soap_added, wash_timeout, drained, drying_timeout, fault;
    logic [7:0] water_level;

    int check_count = 0;
    int error_count = 0;

    wash_plant_model dut (
        .clk(clk), .reset(reset), .door_lock(door_lock), .motor_on(motor_on),
        .fill_valve_on(fill_valve_on), .drain_valve_on(drain_valve_on),
        .soap_wash(soap_wash), .water_wash(water_wash), .done(done),
        .filled(filled), .soap_added(soap_added), .wash_timeout(wash_timeout),
        .drained(drained), .drying_timeout(drying_timeout),
        .water_level(water_level), .fault(fault)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        check_count++;
        if (observed !== expected) begin
            error_count++;
            $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
        end
    endtask

    // Set all controller inputs in one call, then advance to just after the next edge.
    task automatic applyStimulus(input logic lk, input logic mo, input logic fv, input logic dv,
                                 input logic sw, input logic ww, input logic dn);
        door_lock = lk; motor_on = mo; fill_valve_on = fv; drain_valve_on = dv;
        soap_wash = sw; water_wash = ww; done = dn;
        @(posedge clk);
        #1;
    endtask

    task automatic checkAllZero(input string tag);
        checkOutput({tag, ".filled"}, filled, 0);
        checkOutput({tag, ".soap_added"}, soap_added, 0);
        checkOutput({tag, ".wash_timeout"}, wash_timeout, 0);
        checkOutput({tag, ".drained"}, drained, 0);
        checkOutput({tag, ".drying_timeout"}, drying_timeout, 0);
        checkOutput({tag, ".level"}, water_level, 0);
        checkOutput({tag, ".fault"}, fault, 0);
    endtask

    task automatic fillFromEmpty(input string tag);
        for (int e = 1; e <= 4; e++) begin
            applyStimulus(1, 0, 1, 0, 0, 0, 0);
            checkOutput($sformatf("%s.level%0d", tag, e), water_level, e);
            checkOutput($sformatf("%s.filled%0d", tag, e), filled, (e == 4));
        end
    endtask

    initial begin
        reset = 1'b1;
        door_lock = 0; motor_on = 0; fill_valve_on = 0; drain_valve_on = 0;
        soap_wash = 0; water_wash = 0; done = 0;
        #12;
        checkAllZero("reset");
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Fill to the top, then saturate one edge past it.
        fillFromEmpty("fill");
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        checkOutput("fill.sat_level", water_level, 4);
        checkOutput("fill.sat_filled", filled, 1);

        // Soap wash: soap at edge 2, timeout at edge 8, holds saturated, clears on motor off.
        for (int e = 1; e <= 9; e++) begin
            applyStimulus(1, 1, 0, 0, 1, 0, 0);
            checkOutput($sformatf("wash.soap%0d", e), soap_added, (e >= 2));
            checkOutput($sformatf("wash.timeout%0d", e), wash_timeout, (e >= 8));
        end
        applyStimulus(1, 0, 0, 0, 1, 0, 0);
        checkOutput("wash.motor_off_timeout", wash_timeout, 0);
        checkOutput("wash.motor_off_soap", soap_added, 1);

        // Drain: filled drops immediately, tank empty at edge 4 clears soap.
        for (int e = 1; e <= 5; e++) begin
            applyStimulus(1, 0, 0, 1, 0, 0, 0);
            checkOutput($sformatf("drain.level%0d", e), water_level, (e >= 4) ? 0 : 4 - e);
            checkOutput($sformatf("drain.filled%0d", e), filled, 0);
            checkOutput($sformatf("drain.drained%0d", e), drained, (e >= 4));
            checkOutput($sformatf("drain.soap%0d", e), soap_added, (e < 4));
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("drain.release", drained, 0);

        // Valve conflict at level 2: level holds and fault latches.
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        applyStimulus(1, 0, 1, 0, 0, 0, 0);
        checkOutput("conflict.pre_level", water_level, 2);
        checkOutput("conflict.pre_fault", fault, 0);
        for (int e = 1; e <= 3; e++) begin
            applyStimulus(1, 0, 1, 1, 0, 0, 0);
            checkOutput($sformatf("conflict.level%0d", e), water_level, 2);
            checkOutput($sformatf("conflict.fault%0d", e), fault, 1);
        end
        applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("conflict.held_fault", fault, 1);
        checkOutput("conflict.held_level", water_level, 2);

        // Empty the tank, then dry for six edges.
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        applyStimulus(1, 0, 0, 1, 0, 0, 0);
        checkOutput("dry.empty", water_level, 0);
        for (int e = 1; e <= 7; e++) begin
            applyStimulus(1, 0, 0, 0, 0, 0, 0);
            checkOutput($sformatf("dry.timeout%0d", e), drying_timeout, (e >= 6));
        end
        applyStimulus(0, 0, 0, 0, 0, 0, 0);
        checkOutput("dry.unlock", drying_timeout, 0);

        // done clears the dry timer even while it is still qualified.
        for (int e = 1; e <= 6; e++) applyStimulus(1, 0, 0, 0, 0, 0, 0);
        checkOutput("done.pre", drying_timeout, 1);
        applyStimulus(1, 0, 0, 0, 0, 0, 1);
        checkOutput("done.cleared", drying_timeout, 0);
        checkOutput("done.fault_kept", fault, 1);

        // Refill, start washing, then pulse reset between edges.
        fillFromEmpty("refill");
        for (int e = 1; e <= 3; e++) applyStimulus(1, 1, 0, 0, 1, 0, 0);
        checkOutput("midwash.soap", soap_added, 1);
        #2;
        reset = 1'b1;
        #1;
        checkAllZero("async_reset");
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;

        // Unlocked fill is ignored, then the fill sequence replays exactly.
        applyStimulus(0, 0, 1, 0, 0, 0, 0);
        checkOutput("unlocked_fill.level", water_level, 0);
        fillFromEmpty("replay");
        checkOutput("replay.fault", fault, 0);

        $display("CHECKS %0d ERRORS %0d", check_count, error_count);
        $finish;
    end

endmodule
